// File: rtl/avmm_resp_mem256.sv
// Avalon-MM 256-bit responder backed by a byte-enabled word memory.
// Pipelined reads with bounded outstanding count, fixed write wait-states, sticky error flag.
module avmm_resp_mem256 #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          RD_LATENCY  = 2,
    parameter int          MAX_PENDING = 4,
    parameter int          WR_WAIT     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [255:0] avs_writedata,
    input  logic [31:0]  avs_byteenable,
    output logic         avs_waitrequest,
    output logic         avs_readdatavalid,
    output logic [255:0] avs_readdata,
    output logic         err,
    input  logic         err_clr,
    output logic [15:0]  wr_count
);
    localparam int IW = $clog2(DEPTH);

    logic [255:0]        mem [DEPTH];
    logic [RD_LATENCY:1] vld_pipe;
    logic [255:0]        dat_pipe [1:RD_LATENCY];
    logic [3:0]          pending;
    logic [2:0]          wcnt;

    logic [31:0]   offset;
    logic [IW-1:0] idx;
    logic          legal;
    logic          ret;
    logic          rd_acc;
    logic          wr_acc;
    logic          err_set;
    logic [255:0]  rd_data;

    assign offset = avs_address - BASE_ADDR;
    assign idx    = offset[IW+4:5];
    assign legal  = (offset[4:0] == 5'd0) && ({5'd0, offset[31:5]} < 32'(DEPTH));
    assign ret    = vld_pipe[RD_LATENCY];

    // A read that coincides with a return frees a slot, so it is not stalled.
    always_comb begin
        avs_waitrequest = 1'b0;
        if (avs_read)
            avs_waitrequest = (pending == 4'(MAX_PENDING)) && !ret;
        else if (avs_write)
            avs_waitrequest = wcnt < 3'(WR_WAIT);
    end

    assign rd_acc  = avs_read && !avs_waitrequest;
    assign wr_acc  = avs_write && !avs_read && !avs_waitrequest;
    assign err_set = (avs_read && avs_write) || ((rd_acc || wr_acc) && !legal);
    assign rd_data = legal ? mem[idx] : '0;

    assign avs_readdatavalid = vld_pipe[RD_LATENCY];
    assign avs_readdata      = dat_pipe[RD_LATENCY];

    // Data stages only load behind a valid bit, so the output stage holds between returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int k = 1; k <= RD_LATENCY; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc) dat_pipe[1] <= rd_data;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({rd_acc, ret})
                2'b10:   pending <= pending + 4'd1;
                2'b01:   pending <= pending - 4'd1;
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
        end else if (avs_write && !avs_read && (WR_WAIT > 0)) begin
            wcnt <= (wcnt == 3'(WR_WAIT)) ? 3'd0 : wcnt + 3'd1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_acc && legal) begin
            for (int b = 0; b < 32; b++)
                if (avs_byteenable[b]) mem[idx][8*b +: 8] <= avs_writedata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            wr_count <= '0;
        end else begin
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (wr_acc) wr_count <= wr_count + 16'd1;
        end
    end
endmodule
